// File: rtl/uart_pkg.sv
// Shared definitions for the uart_rx bus controller: CPU register map,
// status/control bit positions, uart_rx slave addresses and FSM states.
package uart_pkg;

  localparam logic [1:0] REG_DATA = 2'd0;
  localparam logic [1:0] REG_STAT = 2'd1;
  localparam logic [1:0] REG_CTRL = 2'd2;

  localparam int STAT_OVR   = 7;
  localparam int STAT_FULL  = 6;
  localparam int STAT_EMPTY = 5;

  localparam int CTRL_EN = 0;
  localparam int CTRL_IE = 1;

  localparam logic U_DATA = 1'b0;
  localparam logic U_STAT = 1'b1;

  // uart_rx status word: byte ready and receiver-side overrun
  localparam int U_STAT_RDY = 0;
  localparam int U_STAT_OVR = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POLL = 2'd1,
    READ = 2'd2,
    PUSH = 2'd3
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; a push while full is accepted
// only when a pop happens in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; occupancy alone defines validity
  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// Bus-side controller for uart_rx: polls its status, reads received bytes
// into a FIFO and exposes FIFO/status/control registers to the CPU.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int POLL_DIV = 32
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic       i_cyc,
  input  logic       i_we,
  input  logic [1:0] i_addr,
  input  logic [7:0] i_dat,
  output logic [7:0] o_dat,
  output logic       o_int,
  output logic       o_u_cyc,
  output logic       o_u_addr,
  output logic       o_u_we,
  input  logic [7:0] i_u_dat,
  input  logic       i_u_int
);

  localparam int CW = $clog2(POLL_DIV);

  state_t        state, state_nx;
  logic [CW-1:0] poll_cnt;
  logic          pend;
  logic          ovr;
  logic [7:0]    ctrl;
  logic [7:0]    hold;
  logic          int_q;
  logic          poll_go;
  logic          ovr_set;
  logic          ovr_clr;
  logic          push;
  logic          pop;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic [4:0]    cnt5;
  logic [7:0]    head;

  assign pop     = i_cyc & ~i_we & (i_addr == REG_DATA) & ~empty;
  assign ovr_clr = i_cyc & i_we & (i_addr == REG_STAT) & i_dat[STAT_OVR];
  assign cnt5    = 5'(count);
  assign o_u_we  = 1'b0;
  assign o_int   = int_q;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH), .AW(AW)) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .push      (push),
    .pop       (pop),
    .wr_data   (hold),
    .rd_data   (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  always_comb begin
    state_nx = state;
    o_u_cyc  = 1'b0;
    o_u_addr = U_DATA;
    poll_go  = 1'b0;
    ovr_set  = 1'b0;
    push     = 1'b0;
    case (state)
      IDLE: begin
        poll_go = ctrl[CTRL_EN] &
                  ((poll_cnt == CW'(POLL_DIV-1)) | i_u_int | pend);
        if (poll_go) state_nx = POLL;
      end
      POLL: begin
        o_u_cyc  = 1'b1;
        o_u_addr = U_STAT;
        ovr_set  = i_u_dat[U_STAT_OVR];
        state_nx = i_u_dat[U_STAT_RDY] ? READ : IDLE;
      end
      READ: begin
        o_u_cyc  = 1'b1;
        state_nx = PUSH;
      end
      PUSH: begin
        // A same-cycle CPU pop frees the slot, so a full FIFO still accepts
        push     = ~full | pop;
        ovr_set  = full & ~pop;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= IDLE;
      poll_cnt <= '0;
      pend     <= 1'b0;
      ovr      <= 1'b0;
      ctrl     <= 8'h00;
      int_q    <= 1'b0;
    end else begin
      state <= state_nx;
      if (poll_go)
        poll_cnt <= '0;
      else if (state == IDLE && ctrl[CTRL_EN])
        poll_cnt <= poll_cnt + CW'(1);
      if (poll_go)
        pend <= 1'b0;
      else if (state != IDLE && i_u_int)
        pend <= 1'b1;
      if (ovr_set)
        ovr <= 1'b1;
      else if (ovr_clr)
        ovr <= 1'b0;
      if (i_cyc && i_we && i_addr == REG_CTRL)
        ctrl <= i_dat;
      int_q <= ctrl[CTRL_IE] & ((cnt5 > {1'b0, ctrl[7:4]}) | ovr);
    end
  end

  always_ff @(posedge i_clk) begin
    if (state == READ) hold <= i_u_dat;
  end

  always_comb begin
    o_dat = 8'h00;
    case (i_addr)
      REG_DATA: o_dat = empty ? 8'h00 : head;
      REG_STAT: o_dat = {ovr, full, empty, cnt5};
      REG_CTRL: o_dat = ctrl & 8'hF3;
      default:  o_dat = 8'h00;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl with a behavioural uart_rx slave that
// holds one byte and clears its ready flag when the data register is read.
module tb_uart_rx_ctrl;

  logic       i_clk = 1'b0;
  logic       i_reset_n = 1'b0;
  logic       i_cyc = 1'b0;
  logic       i_we = 1'b0;
  logic [1:0] i_addr = 2'd0;
  logic [7:0] i_dat = 8'h00;
  logic [7:0] o_dat;
  logic       o_int;
  logic       o_u_cyc;
  logic       o_u_addr;
  logic       o_u_we;
  logic [7:0] i_u_dat;
  logic       i_u_int = 1'b0;

  logic       ld = 1'b0;
  logic [7:0] ld_byte = 8'h00;
  logic       u_valid = 1'b0;
  logic [7:0] u_byte = 8'h00;

  int         nchk = 0;
  int         npass = 0;
  logic [7:0] d;
  logic       found;

  uart_rx_ctrl dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_cyc     (i_cyc),
    .i_we      (i_we),
    .i_addr    (i_addr),
    .i_dat     (i_dat),
    .o_dat     (o_dat),
    .o_int     (o_int),
    .o_u_cyc   (o_u_cyc),
    .o_u_addr  (o_u_addr),
    .o_u_we    (o_u_we),
    .i_u_dat   (i_u_dat),
    .i_u_int   (i_u_int)
  );

  always #5 i_clk = ~i_clk;

  always @(posedge i_clk) begin
    if (ld) begin
      u_valid <= 1'b1;
      u_byte  <= ld_byte;
    end else if (o_u_cyc && !o_u_addr) begin
      u_valid <= 1'b0;
    end
  end

  assign i_u_dat = o_u_addr ? {7'b0, u_valid} : u_byte;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
  endtask

  task automatic cyc_n(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  task automatic cpu_wr(input logic [1:0] a, input logic [7:0] v);
    i_cyc = 1'b1; i_we = 1'b1; i_addr = a; i_dat = v;
    @(negedge i_clk);
    i_cyc = 1'b0; i_we = 1'b0;
  endtask

  task automatic cpu_rd(input logic [1:0] a, output logic [7:0] v);
    i_cyc = 1'b1; i_we = 1'b0; i_addr = a;
    #1 v = o_dat;
    @(negedge i_clk);
    i_cyc = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic with_int);
    ld = 1'b1; ld_byte = b; i_u_int = with_int;
    @(negedge i_clk);
    ld = 1'b0; i_u_int = 1'b0;
  endtask

  initial begin
    cyc_n(2);
    chk("rst_u_cyc", o_u_cyc, 0);
    chk("rst_int", o_int, 0);
    i_reset_n = 1'b1;
    cyc_n(1);
    cpu_rd(2'd1, d); chk("rst_stat", d, 8'h20);
    cpu_rd(2'd2, d); chk("rst_ctrl", d, 8'h00);
    cpu_rd(2'd3, d); chk("reg3", d, 8'h00);

    // disabled: interrupts from uart_rx must not start bus cycles
    found = 1'b0;
    send(8'h11, 1'b1);
    repeat (10) begin
      if (o_u_cyc) found = 1'b1;
      @(negedge i_clk);
    end
    chk("dis_no_cyc", found, 0);
    cpu_rd(2'd1, d); chk("dis_stat", d, 8'h20);

    // interrupt-driven read with exact cycle timing
    cpu_wr(2'd2, 8'h01);
    send(8'hA5, 1'b1);
    chk("poll_cyc", o_u_cyc, 1);
    chk("poll_addr", o_u_addr, 1);
    chk("u_we", o_u_we, 0);
    cyc_n(1);
    chk("read_cyc", o_u_cyc, 1);
    chk("read_addr", o_u_addr, 0);
    cyc_n(1);
    chk("push_cyc", o_u_cyc, 0);
    cyc_n(1);
    cpu_rd(2'd1, d); chk("t4_stat", d, 8'h01);
    cpu_rd(2'd0, d); chk("rd_a5", d, 8'hA5);
    cpu_rd(2'd1, d); chk("after_pop", d, 8'h20);

    // background poll finds a byte without any interrupt
    send(8'h3C, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (o_u_cyc && !o_u_addr) begin
        found = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    chk("bg_poll_seen", found, 1);
    cyc_n(3);
    cpu_rd(2'd0, d); chk("bg_byte", d, 8'h3C);
    cpu_rd(2'd1, d); chk("bg_stat", d, 8'h20);

    // overfill: 17 bytes into 16 entries
    for (int k = 0; k < 17; k++) begin
      send(8'(8'h40 + k), 1'b1);
      cyc_n(8);
    end
    cpu_rd(2'd1, d); chk("full_stat", d, 8'hD0);
    cpu_wr(2'd1, 8'h80);
    cpu_rd(2'd1, d); chk("ovr_clr", d, 8'h50);
    for (int k = 0; k < 16; k++) begin
      cpu_rd(2'd0, d); chk("drain", d, 8'(8'h40 + k));
    end
    cpu_rd(2'd1, d); chk("drain_stat", d, 8'h20);
    cpu_rd(2'd0, d); chk("empty_rd", d, 8'h00);

    // threshold interrupt: thr=2 fires at count 3
    cpu_wr(2'd2, 8'h23);
    cpu_rd(2'd2, d); chk("ctrl_rd", d, 8'h23);
    send(8'h61, 1'b1); cyc_n(8);
    send(8'h62, 1'b1); cyc_n(8);
    chk("int_cnt2", o_int, 0);
    send(8'h63, 1'b1); cyc_n(8);
    chk("int_cnt3", o_int, 1);
    cpu_rd(2'd1, d); chk("stat_cnt3", d, 8'h03);
    cpu_rd(2'd0, d); chk("pop_61", d, 8'h61);
    cyc_n(1);
    chk("int_fall", o_int, 0);

    // asynchronous reset while the data read is on the bus
    send(8'h77, 1'b1);
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (o_u_cyc && !o_u_addr) begin
        found = 1'b1;
        break;
      end
      @(negedge i_clk);
    end
    chk("rst_in_read", found, 1);
    i_reset_n = 1'b0;
    #1;
    chk("arst_u_cyc", o_u_cyc, 0);
    chk("arst_int", o_int, 0);
    i_addr = 2'd1;
    #1 chk("arst_stat", o_dat, 8'h20);
    i_addr = 2'd2;
    #1 chk("arst_ctrl", o_dat, 8'h00);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    cyc_n(2);
    chk("post_rst_cyc", o_u_cyc, 0);
    cpu_rd(2'd0, d); chk("post_rst_rd", d, 8'h00);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
